// File: rtl/hello_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hello_scroll_ctrl
//  Purpose  : Scroll-position controller for the HELLO display decoder.
//             A three-state FSM (IDLE / RUN / PAUSE) moves a 3-bit position
//             one step every TICK_DIV cycles while running. In pause, the
//             step button moves it by single steps. A load strobe sets it
//             directly.
//  Macro    : HELLO_SCROLL_BOUNCE_EN - when defined, the position ping-pongs
//             between 0 and 7 instead of wrapping modulo 8.
//  Ports    : clk      - single clock, rising edge
//             rst      - synchronous active-high reset
//             en       - 1 enables scrolling, 0 forces IDLE
//             dir      - 0 increments, 1 decrements the position
//             pause    - button level, rising edge toggles RUN/PAUSE
//             step     - button level, rising edge steps once in PAUSE
//             load     - 1-cycle strobe, loads load_val into the position
//             load_val - 3-bit position to load
//             c        - registered scroll position (decoder select code)
//             tick     - 1-cycle pulse in the cycle c takes a new value
//             paused   - 1 while the FSM is in PAUSE
//  Revision : 1.0 - initial release
// ============================================================================
module hello_scroll_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       dir,
   input  logic       pause,
   input  logic       step,
   input  logic       load,
   input  logic [2:0] load_val,
   output logic [2:0] c,
   output logic       tick,
   output logic       paused
);

   localparam int               DIV_W   = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [DIV_W-1:0] div_cnt;
   logic             pause_d;
   logic             step_d;

   logic             pause_rise;
   logic             step_rise;
   logic             div_adv;
   logic             step_adv;
   logic             advance;
   logic             eff_dir;
   logic [2:0]       c_adv;

`ifdef HELLO_SCROLL_BOUNCE_EN
   logic             bounce;
`endif

   // ---------------------------------------------------------------------
   // Next-state and advance decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      pause_rise = pause & ~pause_d;
      step_rise  = step & ~step_d;

      if (!en) begin
         // Dropping en wins over a pause edge in the same cycle.
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_next = S_RUN;
            S_RUN:   if (pause_rise) state_next = S_PAUSE;
            S_PAUSE: if (pause_rise) state_next = S_RUN;
            default: state_next = S_IDLE;
         endcase
      end

      // en=0 forces IDLE at once, so neither advance source fires then.
      div_adv  = (state == S_RUN) && en && (div_cnt == DIV_MAX);
      step_adv = (state == S_PAUSE) && en && step_rise;
      advance  = div_adv | step_adv;

`ifdef HELLO_SCROLL_BOUNCE_EN
      eff_dir = dir ^ bounce;
`else
      eff_dir = dir;
`endif
      c_adv = eff_dir ? (c - 3'd1) : (c + 3'd1);
   end

   assign paused = (state == S_PAUSE);

   // ---------------------------------------------------------------------
   // State, divider, edge detectors and position
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         c       <= 3'd0;
         tick    <= 1'b0;
         div_cnt <= '0;
         pause_d <= 1'b0;
         step_d  <= 1'b0;
      end else begin
         state   <= state_next;
         pause_d <= pause;
         step_d  <= step;
         tick    <= load | advance;

         // Load takes priority over any advance in the same cycle.
         if (load) begin
            c <= load_val;
         end else if (advance) begin
            c <= c_adv;
         end

         // Counting only in RUN keeps the divider at zero in IDLE/PAUSE, so
         // every entry to RUN starts a full TICK_DIV period.
         if ((state == S_RUN) && en && !load && !div_adv) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
         end
      end
   end

`ifdef HELLO_SCROLL_BOUNCE_EN
   // The direction flips when an advance lands on an end stop. That gives
   // 0..7,6..0,1.. with no wrap jump.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         bounce <= 1'b0;
      end else if (advance &&
                   ((!eff_dir && (c_adv == 3'd7)) ||
                    ( eff_dir && (c_adv == 3'd0)))) begin
         bounce <= ~bounce;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hello_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hello_scroll_ctrl
//  Purpose  : Self-checking bench for hello_scroll_ctrl with TICK_DIV=4.
//             It applies a table of per-cycle input/expected records and
//             then runs hand-written multi-cycle sequences. If
//             HELLO_SCROLL_BOUNCE_EN is defined, it runs the bounce sequence
//             in place of the wrap table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hello_scroll_ctrl;

   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic       pause = 1'b0;
   logic       step = 1'b0;
   logic       load = 1'b0;
   logic [2:0] load_val = 3'd0;
   logic [2:0] c;
   logic       tick;
   logic       paused;

   int passed = 0;
   int total  = 0;

   hello_scroll_ctrl #(.TICK_DIV(TICK_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .pause    (pause),
      .step     (step),
      .load     (load),
      .load_val (load_val),
      .c        (c),
      .tick     (tick),
      .paused   (paused)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic       rst;
      logic       en;
      logic       dir;
      logic       pause;
      logic       step;
      logic       load;
      logic [2:0] lv;
      logic [2:0] exp_c;
      logic       exp_tick;
      logic       exp_paused;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string tag, input logic r, input logic e,
                      input logic d, input logic p, input logic s,
                      input logic l, input logic [2:0] lv,
                      input logic [2:0] ec, input logic et, input logic ep);
      vec_t v;
      v.tag = tag; v.rst = r; v.en = e; v.dir = d; v.pause = p;
      v.step = s; v.load = l; v.lv = lv; v.exp_c = ec;
      v.exp_tick = et; v.exp_paused = ep;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic drive(input logic r, input logic e, input logic d,
                        input logic p, input logic s, input logic l,
                        input logic [2:0] lv);
      rst = r; en = e; dir = d; pause = p; step = s; load = l; load_val = lv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit got;
      int bseq[15];

`ifndef HELLO_SCROLL_BOUNCE_EN
      // Reset, then run upward: c holds for 4 cycles, then steps every 4.
      add("reset0", 1,0,0,0,0,0,0, 0,0,0);
      add("reset1", 1,0,0,0,0,0,0, 0,0,0);
      add("run_entry", 0,1,0,0,0,0,0, 0,0,0);
      for (int k = 1; k <= 8; k++) begin
         for (int j = 0; j < 3; j++)
            add("run_hold", 0,1,0,0,0,0,0, 3'((k-1) % 8),0,0);
         add("run_step", 0,1,0,0,0,0,0, 3'(k % 8),1,0);
      end
      // Decrement: 0 wraps to 7, then 6.
      for (int j = 0; j < 3; j++) add("dec_hold0", 0,1,1,0,0,0,0, 0,0,0);
      add("dec_wrap", 0,1,1,0,0,0,0, 7,1,0);
      for (int j = 0; j < 3; j++) add("dec_hold7", 0,1,1,0,0,0,0, 7,0,0);
      add("dec_step", 0,1,1,0,0,0,0, 6,1,0);
      // Pause edge, then step held for 10 cycles advances once.
      add("pause_on", 0,1,1,1,0,0,0, 6,0,1);
      add("step_edge", 0,1,1,1,1,0,0, 5,1,1);
      for (int j = 0; j < 9; j++) add("step_held", 0,1,1,1,1,0,0, 5,0,1);
      add("buttons_up", 0,1,1,0,0,0,0, 5,0,1);
      add("resume", 0,1,1,1,0,0,0, 5,0,0);
      // A step edge in RUN is ignored. The first advance comes 4 cycles later.
      add("run_step_ign", 0,1,1,1,1,0,0, 5,0,0);
      add("resume_hold", 0,1,1,1,1,0,0, 5,0,0);
      add("resume_hold", 0,1,1,1,0,0,0, 5,0,0);
      add("resume_adv", 0,1,1,1,0,0,0, 4,1,0);
      // Load on the same cycle as a divider advance wins.
      for (int j = 0; j < 3; j++) add("pre_load", 0,1,1,1,0,0,0, 4,0,0);
      add("load_vs_adv", 0,1,1,1,0,1,5, 5,1,0);
      for (int j = 0; j < 3; j++) add("post_load", 0,1,0,1,0,0,0, 5,0,0);
      add("post_load_adv", 0,1,0,1,0,0,0, 6,1,0);
      // Loading the current value still ticks and restarts the divider.
      add("load_same", 0,1,0,1,0,1,6, 6,1,0);
      for (int j = 0; j < 3; j++) add("same_hold", 0,1,0,1,0,0,0, 6,0,0);
      add("same_adv", 0,1,0,1,0,0,0, 7,1,0);
      // en=0 holds c in IDLE with no tick.
      for (int j = 0; j < 6; j++) add("idle_hold", 0,0,0,0,0,0,0, 7,0,0);
      add("rerun", 0,1,0,0,0,0,0, 7,0,0);
      for (int j = 0; j < 3; j++) add("rerun_cnt", 0,1,0,0,0,0,0, 7,0,0);
      // Reset on the edge where the divider would wrap.
      add("rst_mid", 1,1,0,0,0,0,0, 0,0,0);
      add("rst_release", 0,1,0,0,0,0,0, 0,0,0);
      for (int j = 0; j < 3; j++) add("rel_hold", 0,1,0,0,0,0,0, 0,0,0);
      add("rel_adv", 0,1,0,0,0,0,0, 1,1,0);
      // A load in IDLE ticks. A step edge in IDLE is ignored.
      add("to_idle", 0,0,0,0,0,0,0, 1,0,0);
      add("idle_load", 0,0,0,0,0,1,3, 3,1,0);
      add("idle_after", 0,0,0,0,0,0,0, 3,0,0);
      add("idle_step", 0,0,0,0,1,0,0, 3,0,0);
      add("idle_step_lo", 0,0,0,0,0,0,0, 3,0,0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].pause,
               vecs[i].step, vecs[i].load, vecs[i].lv);
         check($sformatf("%s[%0d].c", vecs[i].tag, i), c, vecs[i].exp_c);
         check($sformatf("%s[%0d].tick", vecs[i].tag, i), tick, vecs[i].exp_tick);
         check($sformatf("%s[%0d].paused", vecs[i].tag, i), paused, vecs[i].exp_paused);
      end

      // Measure the latency from entry to RUN until the first tick, bounded.
      drive(1,0,0,0,0,0,0);
      drive(0,1,0,0,0,0,0);
      n = 0; got = 0;
      while (!got && n < 20) begin
         drive(0,1,0,0,0,0,0);
         n++;
         if (tick) got = 1;
      end
      check("first_adv_latency", got ? n : -1, TICK_DIV);
      check("first_adv_value", c, 1);
`else
      // Bounce: 0..7,6..0,1 with no 7->0 jump.
      bseq = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};
      drive(1,0,0,0,0,0,0);
      check("bounce_reset_c", c, 0);
      drive(0,1,0,0,0,0,0);
      foreach (bseq[k]) begin
         n = 0; got = 0;
         while (!got && n < 20) begin
            drive(0,1,0,0,0,0,0);
            n++;
            if (tick) got = 1;
         end
         check($sformatf("bounce_latency[%0d]", k), got ? n : -1, TICK_DIV);
         check($sformatf("bounce_c[%0d]", k), c, bseq[k]);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
